pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
// - Parametrised pipeline stage register for any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Carries LANES payload slots of DATA_W bits each, plus per-lane valid bits.
// - Uses a valid/ready handshake with a one-entry skid buffer, so upstream ready is not combinational on out_ready.
// - Supports flush and freeze controls, and saturating bubble/stall performance counters for the hazard unit.
// PARAMETERS
// - DATA_W  32  bits per lane payload (instr, pc, pc+4, nxt_pc packed by the caller)
// - LANES   1   issue slots per stage (1 = scalar, 2 = dual-issue)
// - CNT_W   16  width of perf counters; they saturate at 2**CNT_W-1
// PORTS
// - CLK          in   1              clock, rising edge
// - nRST         in   1              asynchronous, active-low reset
// - flush        in   1              kill all stage contents (branch/jump mispredict)
// - freeze       in   1              hold all state (d-cache miss, multicycle op)
// - in_valid     in   1              upstream offers a bundle
// - in_ready     out  1              stage accepts the bundle this cycle
// - in_lane_vld  in   LANES          per-lane valid of the offered bundle
// - in_data      in   LANES*DATA_W   lane payloads; lane i at [i*DATA_W +: DATA_W]
// - out_valid    out  1              stage holds a bundle for downstream
// - out_ready    in   1              downstream consumes the bundle
// - out_lane_vld out  LANES          per-lane valid of the held bundle
// - out_data     out  LANES*DATA_W   held payload
// - cnt_clr      in   1              synchronous clear of both counters
// - bubble_cnt   out  CNT_W          cycles with out_valid=0 and freeze=0
// - stall_cnt    out  CNT_W          cycles with out_valid=1, out_ready=0 and freeze=0
// BEHAVIOUR
// - State:
//   - main entry {v, lane_vld, data}, which drives the out_* ports;
//   - skid entry {v, lane_vld, data};
//   - two counters.
// - Reset (nRST=0, async): both entries v=0, lane_vld=0, data=0; counters=0.
//   - Outputs under reset: out_valid=0, out_lane_vld=0, out_data=0.
// - in_ready = !skid.v && !freeze && !flush.
//   - accept = in_valid && in_ready.
//   - xfer = out_valid && out_ready && !freeze.
// - Priority per cycle: flush > freeze > normal.
// - flush=1: both entries go to v=0 with data and lane_vld zeroed next cycle; input is discarded. This holds even when freeze=1.
// - freeze=1 (no flush): every entry bit is held and in_ready=0. A downstream out_ready is ignored (no xfer).
// - Normal operation, skid empty:
//   - main empty, or xfer: main <= accept ? in : zero bubble.
//   - main full, no xfer: main held; if accept, skid <= in.
// - Normal operation, skid full (in_ready=0):
//   - xfer: main <= skid, skid <= zero.
//   - otherwise: hold.
// - Latency: in -> out is 1 cycle when downstream is flowing. Full throughput is 1 bundle per cycle. Capacity is 2 bundles.
// - Ordering is strictly FIFO. Skid data never bypasses main.
// - An invalid main entry always presents data=0 and lane_vld=0 (zero bubble).
// - in_lane_vld=0 with in_valid=1 is legal: the bundle is accepted and carried as a valid bundle with empty lanes.
// - Counters are evaluated every cycle with freeze=0:
//   - bubble_cnt += !out_valid;
//   - stall_cnt += out_valid && !out_ready;
//   - both saturate at all-ones, never wrap.
//   - cnt_clr has priority over increment.
//   - Counters are not affected by flush.
// STRUCTURE
// - pipe_pkg: localparam defaults; typedef struct {logic v; logic [LANES-1:0] lv; logic [LANES*DATA_W-1:0] d;} entry template. A macro or generic is used because the widths are parametric.
// - Sub-module sat_counter #(CNT_W) with ports inc, clr, q. It is instantiated twice.
// - Main and skid registers: single always_ff with async reset. Handshake signals: always_comb.
// TESTING
// - Stream 8 bundles (data=0x100+i), out_ready=1 -> each appears 1 cycle later; in_ready stays 1; bubble_cnt counts only the fill and drain cycles.
// - Backpressure: out_ready=0 for 3 cycles during the stream -> skid fills, in_ready=0 from the 2nd cycle; after release, order is preserved and there is no loss or duplication.
// - flush with main and skid both full (and in_valid=1) -> next cycle out_valid=0, out_data=0, in_ready=1; the flushed bundles never appear.
// - freeze for 4 cycles with out_ready=1 -> out_data stable, no xfer, in_ready=0, counters frozen; flush+freeze together -> flush wins.
// - Saturation: CNT_W=4, 20 idle cycles -> bubble_cnt=15; then cnt_clr=1 together with an idle cycle -> 0.
// - Async reset asserted mid-stream between clock edges -> all outputs 0 immediately; LANES=2 run: lane_vld=2'b01 carried unchanged with its payload.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared defaults for the skid-buffered pipeline stage
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_LANES  = 1;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// rtl/pipe_stage_skid_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    // Clear wins over increment; the counter sticks at all-ones instead of wrapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with one-entry skid buffer and perf counters
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    flush,
    input  logic                    freeze,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_vld,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_vld,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        bubble_cnt,
    output logic [CNT_W-1:0]        stall_cnt
);

    // Entry layout depends on the parameters, so it is declared here rather than in the package.
    typedef struct packed {
        logic                    v;
        logic [LANES-1:0]        lv;
        logic [LANES*DATA_W-1:0] d;
    } entry_t;

    entry_t main_q;
    entry_t skid_q;
    entry_t in_e;
    logic   accept;
    logic   xfer;

    always_comb begin
        in_ready = !skid_q.v && !freeze && !flush;
        accept   = in_valid && in_ready;
        xfer     = main_q.v && out_ready && !freeze;
        in_e     = '{v: 1'b1, lv: in_lane_vld, d: in_data};
    end

    // An empty main entry is always all-zero, so out_* need no extra masking.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (!freeze) begin
            if (!skid_q.v) begin
                if (!main_q.v || xfer) begin
                    main_q <= accept ? in_e : '0;
                end else if (accept) begin
                    skid_q <= in_e;
                end
            end else if (xfer) begin
                main_q <= skid_q;
                skid_q <= '0;
            end
        end
    end

    assign out_valid    = main_q.v;
    assign out_lane_vld = main_q.lv;
    assign out_data     = main_q.d;

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (!freeze && !main_q.v),
        .clr  (!freeze && cnt_clr),
        .q    (bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (!freeze && main_q.v && !out_ready),
        .clr  (!freeze && cnt_clr),
        .q    (stall_cnt)
    );

endmodule
